// File: rtl/seq_mult_pkg.sv
// ============================================================================
// seq_mult_pkg : shared ALU constants for the sequential multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t RUN  = 2'b01;
  localparam state_t DONE = 2'b10;

endpackage

`default_nettype wire

// File: rtl/seq_mult_rca_w.sv
// ============================================================================
// full_adder / rca_w : one-bit full-adder cell and the WIDTH-bit ripple chain
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;
  assign cout       = w_carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_carry[i]),
      .s    (s[i]),
      .cout (w_carry[i+1])
    );
  end

endmodule

`default_nettype wire

// File: rtl/seq_mult.sv
// ============================================================================
// seq_mult : unsigned shift-add multiplier, one partial product per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_accept;

  // Operands are only taken when not iterating; start during RUN is ignored.
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_addend = r_acc[0] ? r_mcand : '0;
  assign product  = r_acc;

  rca_w #(.WIDTH(WIDTH)) u_rca (
    .a    (r_acc[2*WIDTH-1:WIDTH]),
    .b    (w_addend),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = start ? RUN : IDLE;
      RUN:     w_next_state = (r_cnt == C_LAST) ? DONE : RUN;
      DONE:    w_next_state = start ? RUN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // The adder carry-out becomes the new MSB so no product bit is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_mcand <= a;
      r_acc   <= {{WIDTH{1'b0}}, b};
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
// ============================================================================
// tb_seq_mult : self-checking bench for seq_mult against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_mult;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes busy/done from the first cycle after acceptance until done.
  // Optionally pulses start (a=9,b=9) at iteration inj to probe the ignore rule.
  task automatic wait_done(input int inj, output int busy_n, output int overlap, output bit timeout);
    busy_n = 0; overlap = 0; timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (busy && done) overlap++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) busy_n++;
      if (i == inj) begin a = 9; b = 9; start = 1'b1; end
      if (inj >= 0 && i == inj + 1) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: busy=%b done=%b product=%h, want 0 0 0", i, busy, done, product);
      end
    end
  endtask

  task automatic test_basic;
    int bn, ov; bit to;
    start_op(3, 5);
    wait_done(-1, bn, ov, to);
    checks++;
    if (to || bn != W || ov != 0) begin
      errors++;
      $display("FAIL basic_timing: timeout=%0d busy_cycles=%0d overlap=%0d, want 0 %0d 0", to, bn, ov, W);
    end
    checks++;
    if (product !== 64'h0F) begin
      errors++;
      $display("FAIL basic_product: got %h want %h", product, 64'h0F);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b busy=%b after done cycle, want 0 0", done, busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (product !== 64'h0F) begin
      errors++;
      $display("FAIL basic_hold: got %h want %h", product, 64'h0F);
    end
  endtask

  task automatic test_directed;
    logic [31:0] xa [6] = '{32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h0, 32'hDEADBEEF, 32'h1};
    logic [31:0] xb [6] = '{32'hFFFFFFFF, 32'h2,        32'h0,        32'hCAFEF00D, 32'h1, 32'hFFFFFFFF};
    int bn, ov; bit to;
    for (int k = 0; k < 6; k++) begin
      start_op(xa[k], xb[k]);
      wait_done(-1, bn, ov, to);
      checks++;
      if (to || bn != W || ov != 0 || product !== ref_mul(xa[k], xb[k])) begin
        errors++;
        $display("FAIL directed[%0d] %h*%h: product=%h busy_cycles=%0d timeout=%0d overlap=%0d, want %h %0d",
                 k, xa[k], xb[k], product, bn, to, ov, ref_mul(xa[k], xb[k]), W);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int bn, ov, extra; bit to;
    start_op(7, 6);
    wait_done(9, bn, ov, to);
    checks++;
    if (to || bn != W || product !== 64'd42) begin
      errors++;
      $display("FAIL busy_start: product=%h busy_cycles=%0d timeout=%0d, want %h %0d", product, bn, to, 64'd42, W);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0 || product !== 64'd42) begin
      errors++;
      $display("FAIL busy_start_after: extra_cycles=%0d product=%h, want 0 %h", extra, product, 64'd42);
    end
  endtask

  task automatic test_back_to_back;
    int bn, ov; bit to;
    start_op(7, 6);
    wait_done(-1, bn, ov, to);
    checks++;
    if (to || product !== 64'd42) begin
      errors++;
      $display("FAIL b2b_first: product=%h timeout=%0d, want %h", product, to, 64'd42);
    end
    a = 32'h10000; b = 32'h10000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(-1, bn, ov, to);
    checks++;
    if (to || bn != W || ov != 0 || product !== 64'h0000000100000000) begin
      errors++;
      $display("FAIL b2b_second: product=%h busy_cycles=%0d timeout=%0d, want %h %0d",
               product, bn, to, 64'h0000000100000000, W);
    end
  endtask

  task automatic test_reset_mid;
    int bn, ov, seen; bit to;
    start_op(5, 5);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset_async: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: active_cycles=%0d, want 0", seen);
    end
    start_op(5, 5);
    wait_done(-1, bn, ov, to);
    checks++;
    if (to || bn != W || product !== 64'd25) begin
      errors++;
      $display("FAIL reset_restart: product=%h busy_cycles=%0d timeout=%0d, want %h %0d", product, bn, to, 64'd25, W);
    end
  endtask

  task automatic test_random;
    logic [31:0] x, y;
    int bn, ov; bit to;
    for (int k = 0; k < 16; k++) begin
      x = $urandom;
      y = $urandom;
      if (k % 5 == 4) x = x >> (k % 32);
      start_op(x, y);
      wait_done(-1, bn, ov, to);
      checks++;
      if (to || bn != W || ov != 0 || product !== ref_mul(x, y)) begin
        errors++;
        $display("FAIL random[%0d] %h*%h: product=%h busy_cycles=%0d timeout=%0d, want %h %0d",
                 k, x, y, product, bn, to, ref_mul(x, y), W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
